amm_sram_arb: RTL and testbench
===============================

// Module: amm_sram_arb
// PURPOSE
//  Two-master arbiter sharing one single-port 32-bit SRAM between two Avalon MM slave ports.
//  Sits between two bus masters (e.g. CPU and DMA) and an SRAM macro.
//  Round-robin grant, one transaction at a time.
//  Word-wide access with byte enables; no sub-word serialisation.
// PARAMETERS
//  P_ASIZE   10  SRAM word-address width; AMM byte address bits [P_ASIZE+1:2] used, [1:0] ignored
//  P_RD_LAT  1   SRAM read latency in clocks after sram_re (legal 1..3)
// PORTS
//  clk          in   1          clock, all logic on rising edge
//  reset        in   1          asynchronous, active-high reset
//  amm0         -    amm_if     AMM slave port 0 (address, byteenable[3:0], read, write, writedata[31:0], readdata[31:0], waitrequest)
//  amm1         -    amm_if     AMM slave port 1, same fields
//  sram_addr    out  P_ASIZE    SRAM word address
//  sram_wdata   out  32         SRAM write data
//  sram_be      out  4          SRAM byte write enables
//  sram_we      out  1          SRAM write strobe, one cycle per write
//  sram_re      out  1          SRAM read strobe, one cycle per read
//  sram_rdata   in   32         SRAM read data, valid P_RD_LAT cycles after sram_re
// BEHAVIOUR
//  - Reset: state IDLE; sram_we=0, sram_re=0, sram_be=0; amm0/amm1.waitrequest=1; readdata=0; last_grant=1.
//  - All outputs registered. waitrequest is 1 on a port except in its single ACK cycle.
//  - FSM states IDLE, WR, RD, RWAIT, ACK:
//    IDLE: requesters = ports with read|write high. If none: stay.
//      One request: grant it. Both: grant the port != last_grant.
//      Latch grant, address, writedata, byteenable.
//      Write with byteenable!=0 -> WR. Write with byteenable==0 -> ACK, no SRAM access.
//      Read -> RD. read&write together on a port (protocol violation) is treated as write.
//    WR: sram_we=1, sram_addr/wdata/be from latch for exactly this cycle -> ACK.
//    RD: sram_re=1, sram_addr from latch, sram_be=0 -> RWAIT; load lat_cnt=P_RD_LAT-1.
//    RWAIT: decrement lat_cnt. At 0, capture sram_rdata into granted port readdata -> ACK.
//    ACK: granted waitrequest=0 for one cycle; last_grant<=grant -> IDLE.
//  - Latency, request sampled in IDLE at cycle N:
//    write ack (waitrequest low) in cycle N+2; zero-byte write ack in N+1; read ack in N+2+P_RD_LAT.
//  - Throughput: a new grant at the earliest in the cycle after ACK. Back-to-back writes: one per 3 cycles.
//  - readdata of the non-granted port holds its previous value. readdata is valid whenever that port's waitrequest=0.
//  - Master must hold its request stable until waitrequest=0. Request changes after grant are ignored (latched values used).
//  - Requests arriving on the other port during a transaction wait. No queue; starvation-free by round-robin.
//  - Reset mid-operation:
//    - Asynchronously returns to the reset values above.
//    - Any in-flight SRAM strobe is dropped.
//    - The interrupted master is never acked and must reissue.
// CONFIGURATION
//  AMM_SRAM_ARB_FIXED_PRIO_EN
//    defined: port 0 always wins when both request; last_grant unused; port 1 may starve.
//    undefined (default): round-robin as above.
// TESTING
//  1. Port0 write addr 0x40, data 0xDEADBEEF, be 4'hF -> sram_we high 1 cycle, sram_addr=0x10, sram_wdata=0xDEADBEEF, sram_be=4'hF; amm0.waitrequest low at N+2 only.
//  2. Then port1 read addr 0x40, P_RD_LAT=1 -> sram_re 1 cycle at addr 0x10; amm1.readdata=0xDEADBEEF with waitrequest low at N+3. Repeat with P_RD_LAT=3 -> ack at N+5.
//  3. Both ports issue continuous writes (port0 data 0xA0+k, port1 0xB0+k) -> grant order 0,1,0,1...; SRAM write stream interleaves; 8 each completed in 48 cycles.
//  4. Port0 write be 4'b0010 data 0x12345678 -> sram_be=0010, sram_wdata=0x12345678. Write with be 4'h0 -> no sram_we, ack at N+1.
//  5. Port0 read in RWAIT (P_RD_LAT=3), assert reset 1 cycle mid-wait -> waitrequest both 1, sram_re=0 immediately. Reissued read completes with correct data.
//  6. With AMM_SRAM_ARB_FIXED_PRIO_EN, both ports requesting continuously -> only port0 granted; port1 granted in the first IDLE after port0 drops its request.

Source files
------------

// File: rtl/amm_sram_arb_if.sv
// Avalon-MM slave-side signal bundle used by amm_sram_arb.
// Byte address is P_ASIZE+2 bits wide; the arbiter ignores bits [1:0].
interface amm_if #(
  parameter int P_ASIZE = 10
) ();
  logic [P_ASIZE+1:0] address;
  logic [3:0]         byteenable;
  logic               read;
  logic               write;
  logic [31:0]        writedata;
  logic [31:0]        readdata;
  logic               waitrequest;

  modport slave (
    input  address, byteenable, read, write, writedata,
    output readdata, waitrequest
  );

  modport master (
    output address, byteenable, read, write, writedata,
    input  readdata, waitrequest
  );
endinterface

// File: rtl/amm_sram_arb.sv
// Two-port Avalon-MM arbiter in front of one single-port 32-bit SRAM, one transaction at a time.
// Optional build macro AMM_SRAM_ARB_FIXED_PRIO_EN: port 0 always wins contention (default round-robin).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | pick a requester, latch its transfer, issue the SRAM strobe
// S_WR    | SRAM write strobe is on the bus this cycle
// S_RD    | SRAM read strobe is on the bus this cycle
// S_RWAIT | counting down the SRAM read latency, then capture readdata
// S_ACK   | granted port sees waitrequest low for exactly this cycle
module amm_sram_arb #(
  parameter int P_ASIZE  = 10,
  parameter int P_RD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  amm_if.slave               amm0,
  amm_if.slave               amm1,
  output logic [P_ASIZE-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  output logic [3:0]         sram_be,
  output logic               sram_we,
  output logic               sram_re,
  input  logic [31:0]        sram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RWAIT,
    S_ACK
  } state_t;

  localparam logic [1:0] LAT_INIT = 2'(P_RD_LAT - 1);

  state_t             state;
  logic               grant;
  logic [1:0]         lat_cnt;
  logic               req0;
  logic               req1;
  logic               pick1;
  logic               sel_write;
  logic [3:0]         sel_be;
  logic [31:0]        sel_wdata;
  logic [P_ASIZE-1:0] sel_addr;
  logic               unused_addr_lsb;

  assign req0 = amm0.read | amm0.write;
  assign req1 = amm1.read | amm1.write;

  // The two byte-offset bits never reach the SRAM: accesses are whole words.
  assign unused_addr_lsb = ^{amm0.address[1:0], amm1.address[1:0]};

`ifdef AMM_SRAM_ARB_FIXED_PRIO_EN
  assign pick1 = req1 & ~req0;
`else
  logic last_grant;

  assign pick1 = req1 & (~req0 | ~last_grant);
`endif

  always_comb begin
    sel_write = amm0.write;
    sel_be    = amm0.byteenable;
    sel_wdata = amm0.writedata;
    sel_addr  = amm0.address[P_ASIZE+1:2];
    if (pick1) begin
      sel_write = amm1.write;
      sel_be    = amm1.byteenable;
      sel_wdata = amm1.writedata;
      sel_addr  = amm1.address[P_ASIZE+1:2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      grant            <= 1'b0;
`ifndef AMM_SRAM_ARB_FIXED_PRIO_EN
      last_grant       <= 1'b1;
`endif
      lat_cnt          <= 2'd0;
      sram_addr        <= '0;
      sram_wdata       <= 32'd0;
      sram_be          <= 4'd0;
      sram_we          <= 1'b0;
      sram_re          <= 1'b0;
      amm0.waitrequest <= 1'b1;
      amm1.waitrequest <= 1'b1;
      amm0.readdata    <= 32'd0;
      amm1.readdata    <= 32'd0;
    end else begin
      sram_we <= 1'b0;
      sram_re <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 | req1) begin
            grant     <= pick1;
            sram_addr <= sel_addr;
            // read&write together on one port is resolved as a write
            if (sel_write) begin
              sram_wdata <= sel_wdata;
              if (sel_be != 4'd0) begin
                sram_we <= 1'b1;
                sram_be <= sel_be;
                state   <= S_WR;
              end else begin
                amm0.waitrequest <= pick1;
                amm1.waitrequest <= ~pick1;
                state            <= S_ACK;
              end
            end else begin
              sram_re <= 1'b1;
              sram_be <= 4'd0;
              state   <= S_RD;
            end
          end
        end
        S_WR: begin
          sram_be          <= 4'd0;
          amm0.waitrequest <= grant;
          amm1.waitrequest <= ~grant;
          state            <= S_ACK;
        end
        S_RD: begin
          lat_cnt <= LAT_INIT;
          state   <= S_RWAIT;
        end
        S_RWAIT: begin
          if (lat_cnt == 2'd0) begin
            if (grant) begin
              amm1.readdata <= sram_rdata;
            end else begin
              amm0.readdata <= sram_rdata;
            end
            amm0.waitrequest <= grant;
            amm1.waitrequest <= ~grant;
            state            <= S_ACK;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        S_ACK: begin
          amm0.waitrequest <= 1'b1;
          amm1.waitrequest <= 1'b1;
`ifndef AMM_SRAM_ARB_FIXED_PRIO_EN
          last_grant       <= grant;
`endif
          state            <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amm_sram_arb.sv
// Directed bench for amm_sram_arb: one instance with read latency 1 backed by a RAM model,
// one with read latency 3 backed by an address-derived ROM model.
module tb_amm_sram_arb;

  logic        clk;
  logic        reset_a;
  logic        reset_b;

  logic [9:0]  sram_addr_a, sram_addr_b;
  logic [31:0] sram_wdata_a, sram_wdata_b;
  logic [3:0]  sram_be_a, sram_be_b;
  logic        sram_we_a, sram_we_b;
  logic        sram_re_a, sram_re_b;
  logic [31:0] sram_rdata_a, sram_rdata_b;

  amm_if #(.P_ASIZE(10)) a0 ();
  amm_if #(.P_ASIZE(10)) a1 ();
  amm_if #(.P_ASIZE(10)) b0 ();
  amm_if #(.P_ASIZE(10)) b1 ();

  amm_sram_arb #(.P_ASIZE(10), .P_RD_LAT(1)) dut_a (
    .clk        (clk),
    .reset      (reset_a),
    .amm0       (a0),
    .amm1       (a1),
    .sram_addr  (sram_addr_a),
    .sram_wdata (sram_wdata_a),
    .sram_be    (sram_be_a),
    .sram_we    (sram_we_a),
    .sram_re    (sram_re_a),
    .sram_rdata (sram_rdata_a)
  );

  amm_sram_arb #(.P_ASIZE(10), .P_RD_LAT(3)) dut_b (
    .clk        (clk),
    .reset      (reset_b),
    .amm0       (b0),
    .amm1       (b1),
    .sram_addr  (sram_addr_b),
    .sram_wdata (sram_wdata_b),
    .sram_be    (sram_be_b),
    .sram_we    (sram_we_b),
    .sram_re    (sram_re_b),
    .sram_rdata (sram_rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model, latency 1: read data appears only in the cycle after sram_re.
  logic [31:0] mem_a [1024];
  logic [31:0] pipe_a;
  always @(posedge clk) begin
    if (sram_we_a) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_be_a[i]) mem_a[sram_addr_a][8*i +: 8] <= sram_wdata_a[8*i +: 8];
      end
    end
    pipe_a <= sram_re_a ? mem_a[sram_addr_a] : 32'd0;
  end
  assign sram_rdata_a = pipe_a;

  // ROM model, latency 3: word at address w reads as 0xC0DE0000 | w.
  logic [31:0] pipe_b [3];
  always @(posedge clk) begin
    pipe_b[0] <= sram_re_b ? {16'hC0DE, 6'd0, sram_addr_b} : 32'd0;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign sram_rdata_b = pipe_b[2];

  int n_vec = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] wq [$];
  logic [31:0] ord [$];
  int          k0, k1, done_cyc;
  logic [31:0] exp_w, exp_o;

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    a0.address = '0; a0.byteenable = 4'd0; a0.read = 1'b0; a0.write = 1'b0; a0.writedata = 32'd0;
    a1.address = '0; a1.byteenable = 4'd0; a1.read = 1'b0; a1.write = 1'b0; a1.writedata = 32'd0;
    b0.address = '0; b0.byteenable = 4'd0; b0.read = 1'b0; b0.write = 1'b0; b0.writedata = 32'd0;
    b1.address = '0; b1.byteenable = 4'd0; b1.read = 1'b0; b1.write = 1'b0; b1.writedata = 32'd0;
    tick();
    tick();

    // reset values
    chk("rst_wait0", a0.waitrequest, 1);
    chk("rst_wait1", a1.waitrequest, 1);
    chk("rst_we", sram_we_a, 0);
    chk("rst_re", sram_re_a, 0);
    chk("rst_be", sram_be_a, 0);
    chk("rst_rdata0", a0.readdata, 0);
    chk("rst_rdata1", a1.readdata, 0);
    chk("rst_b_wait0", b0.waitrequest, 1);
    reset_a = 1'b0;
    reset_b = 1'b0;
    tick();

    // port0 full-word write
    a0.address = 12'h040; a0.writedata = 32'hDEADBEEF; a0.byteenable = 4'hF; a0.write = 1'b1;
    tick();
    chk("wr_we", sram_we_a, 1);
    chk("wr_addr", sram_addr_a, 32'h10);
    chk("wr_wdata", sram_wdata_a, 32'hDEADBEEF);
    chk("wr_be", sram_be_a, 4'hF);
    chk("wr_wait0_n1", a0.waitrequest, 1);
    tick();
    chk("wr_we_off", sram_we_a, 0);
    chk("wr_ack0", a0.waitrequest, 0);
    chk("wr_wait1_held", a1.waitrequest, 1);
    a0.write = 1'b0;
    tick();
    chk("wr_wait0_after", a0.waitrequest, 1);

    // port1 read back, latency 1
    a1.address = 12'h040; a1.read = 1'b1;
    tick();
    chk("rd_re", sram_re_a, 1);
    chk("rd_addr", sram_addr_a, 32'h10);
    chk("rd_be", sram_be_a, 0);
    tick();
    chk("rd_re_off", sram_re_a, 0);
    chk("rd_wait1_n2", a1.waitrequest, 1);
    tick();
    chk("rd_ack1", a1.waitrequest, 0);
    chk("rd_data1", a1.readdata, 32'hDEADBEEF);
    chk("rd_data0_held", a0.readdata, 0);
    a1.read = 1'b0;
    tick();

    // both ports stream 8 writes each
    k0 = 0; k1 = 0; done_cyc = 0;
    a0.address = 12'h080; a0.byteenable = 4'hF; a0.writedata = 32'hA0; a0.write = 1'b1;
    a1.address = 12'h084; a1.byteenable = 4'hF; a1.writedata = 32'hB0; a1.write = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (sram_we_a) wq.push_back(sram_wdata_a);
      if (!a0.waitrequest) begin
        ord.push_back(32'd0);
        k0++;
        if (k0 == 8) a0.write = 1'b0;
        else a0.writedata = 32'hA0 + 32'(k0);
      end
      if (!a1.waitrequest) begin
        ord.push_back(32'd1);
        k1++;
        if (k1 == 8) a1.write = 1'b0;
        else a1.writedata = 32'hB0 + 32'(k1);
      end
      if (k0 + k1 == 16 && done_cyc == 0) done_cyc = c;
    end
    chk("stream_done_cycle", 32'(done_cyc), 32'd47);
    chk("stream_writes", 32'(wq.size()), 32'd16);
    chk("stream_acks", 32'(ord.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
`ifdef AMM_SRAM_ARB_FIXED_PRIO_EN
      exp_w = (i < 8) ? 32'hA0 + 32'(i) : 32'hB0 + 32'(i - 8);
      exp_o = (i < 8) ? 32'd0 : 32'd1;
`else
      exp_w = (i % 2 == 0) ? 32'hA0 + 32'(i / 2) : 32'hB0 + 32'(i / 2);
      exp_o = 32'(i % 2);
`endif
      chk($sformatf("stream_wdata[%0d]", i), (i < wq.size()) ? wq[i] : 32'hXXXXXXXX, exp_w);
      chk($sformatf("stream_grant[%0d]", i), (i < ord.size()) ? ord[i] : 32'hXXXXXXXX, exp_o);
    end

    // partial byte-enable write, then zero-byte write
    a0.address = 12'h040; a0.writedata = 32'h12345678; a0.byteenable = 4'b0010; a0.write = 1'b1;
    tick();
    chk("be2_we", sram_we_a, 1);
    chk("be2_be", sram_be_a, 4'b0010);
    chk("be2_wdata", sram_wdata_a, 32'h12345678);
    tick();
    chk("be2_ack0", a0.waitrequest, 0);
    a0.write = 1'b0;
    tick();
    a0.byteenable = 4'h0; a0.writedata = 32'hFFFFFFFF; a0.write = 1'b1;
    tick();
    chk("be0_ack0_n1", a0.waitrequest, 0);
    chk("be0_no_we", sram_we_a, 0);
    a0.write = 1'b0;
    tick();
    chk("be0_wait0_after", a0.waitrequest, 1);
    chk("be0_no_we_after", sram_we_a, 0);
    a1.address = 12'h040; a1.read = 1'b1;
    tick();
    tick();
    tick();
    chk("merge_ack1", a1.waitrequest, 0);
    chk("merge_data1", a1.readdata, 32'hDEAD56EF);
    a1.read = 1'b0;
    tick();

    // latency-3 instance: port1 read acks at N+5
    b1.address = 12'h040; b1.read = 1'b1;
    tick();
    chk("l3_re", sram_re_b, 1);
    chk("l3_addr", sram_addr_b, 32'h10);
    tick();
    tick();
    tick();
    chk("l3_wait1_n4", b1.waitrequest, 1);
    tick();
    chk("l3_ack1_n5", b1.waitrequest, 0);
    chk("l3_data1", b1.readdata, 32'hC0DE0010);
    b1.read = 1'b0;
    tick();
    b0.address = 12'h044; b0.read = 1'b1;
    tick();
    tick();
    tick();
    tick();
    tick();
    chk("l3_ack0", b0.waitrequest, 0);
    chk("l3_data0", b0.readdata, 32'hC0DE0011);
    b0.read = 1'b0;
    tick();

    // reset in the middle of a read wait; master keeps its request up
    b0.address = 12'h048; b0.read = 1'b1;
    tick();
    chk("rst_mid_re_before", sram_re_b, 1);
    tick();
    reset_b = 1'b1;
    #1;
    chk("rst_mid_wait0", b0.waitrequest, 1);
    chk("rst_mid_wait1", b1.waitrequest, 1);
    chk("rst_mid_re", sram_re_b, 0);
    chk("rst_mid_rdata0", b0.readdata, 0);
    tick();
    reset_b = 1'b0;
    tick();
    chk("reissue_re", sram_re_b, 1);
    chk("reissue_addr", sram_addr_b, 32'h12);
    tick();
    tick();
    chk("reissue_wait0_n3", b0.waitrequest, 1);
    tick();
    chk("reissue_wait0_n4", b0.waitrequest, 1);
    tick();
    chk("reissue_ack0", b0.waitrequest, 0);
    chk("reissue_data0", b0.readdata, 32'hC0DE0012);
    b0.read = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
